// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite line scheduler: attribute word
// layout, active-list entry layout and the sequencer state encoding.
package sprite_pkg;

    localparam int          LINE_W      = 640;
    localparam logic [23:0] BG_COLOR    = 24'h3DBCFB;
    localparam logic [23:0] TRANSPARENT = 24'hFF00FF;

    typedef struct packed {
        logic [6:0] dim;
        logic [4:0] id;
        logic [9:0] y;
        logic [9:0] x;
    } sprite_attr_t;

    typedef struct packed {
        logic [9:0] x;
        logic [6:0] row;
        logic [6:0] dim;
        logic [4:0] id;
    } active_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SCAN,
        FETCH,
        DONE
    } state_t;

endpackage

// File: rtl/sprite_active_list.sv
// Small register file holding the sprites that hit the current line, in
// push order; pushes beyond capacity are ignored (the caller flags overflow).
module sprite_active_list
    import sprite_pkg::*;
#(
    parameter int MAX_ACTIVE = 8
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        i_clear,
    input  logic                                        i_push,
    input  active_entry_t                               i_entry,
    input  logic [((MAX_ACTIVE > 1) ? $clog2(MAX_ACTIVE) : 1)-1:0] i_rd_idx,
    output logic                                        o_full,
    output logic [$clog2(MAX_ACTIVE + 1)-1:0]           o_count,
    output active_entry_t                               o_rd_entry
);

    localparam int IDX_W = (MAX_ACTIVE > 1) ? $clog2(MAX_ACTIVE) : 1;
    localparam int CNT_W = $clog2(MAX_ACTIVE + 1);

    active_entry_t    r_list [MAX_ACTIVE];
    logic [CNT_W-1:0] r_count;
    logic             w_accept;

    assign o_full     = (r_count == CNT_W'(MAX_ACTIVE));
    assign w_accept   = i_push && !o_full && !i_clear;
    assign o_count    = r_count;
    assign o_rd_entry = r_list[i_rd_idx];

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_list[IDX_W'(r_count)] <= i_entry;
        end
    end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-line sequencer: clears the prefetch line buffer, scans the attribute
// table for sprites on the line, then streams their ROM rows into the buffer.
module sprite_line_scheduler #(
    parameter int          NUM_SLOTS   = 20,
    parameter int          MAX_ACTIVE  = 8,
    parameter int          MAX_DIM     = 32,
    parameter int          LINE_W      = sprite_pkg::LINE_W,
    parameter logic [23:0] BG_COLOR    = sprite_pkg::BG_COLOR,
    parameter logic [23:0] TRANSPARENT = sprite_pkg::TRANSPARENT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic [9:0]  line_y,
    output logic [4:0]  attr_idx,
    input  logic [31:0] attr_data,
    output logic [4:0]  rom_sel,
    output logic [9:0]  rom_addr,
    input  logic [23:0] rom_data,
    output logic        lb_we,
    output logic [9:0]  lb_addr,
    output logic [23:0] lb_data,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        late
);

    import sprite_pkg::*;

    localparam int IDX_W = (MAX_ACTIVE > 1) ? $clog2(MAX_ACTIVE) : 1;
    localparam int CNT_W = $clog2(MAX_ACTIVE + 1);
    // One counter serves the clear sweep, the slot scan and the fetch column;
    // it must also reach any 7-bit dim, i.e. up to 4*MAX_DIM at the default.
    localparam int COL_W = (LINE_W > 4 * MAX_DIM) ? $clog2(LINE_W) : $clog2(4 * MAX_DIM);

    state_t           r_state;
    logic [9:0]       r_line_y;
    logic [COL_W-1:0] r_col;
    logic [IDX_W-1:0] r_fidx;
    logic             r_drain;
    logic             r_busy;
    logic             r_done;
    logic             r_overflow;
    logic             r_late;
    logic             r_vld_p1;
    logic [9:0]       r_addr_p1;
    logic             r_inb_p1;

    sprite_attr_t     w_attr;
    active_entry_t    w_new;
    active_entry_t    w_cur;
    logic             w_eval;
    logic             w_empty;
    logic             w_hit;
    logic             w_push;
    logic             w_full;
    logic [10:0]      w_diff;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_next;
    logic             w_issue;
    logic [9:0]       w_rom_addr;
    logic [10:0]      w_col_abs;

    assign w_attr       = attr_data;
    assign w_eval       = (r_state == SCAN) && (r_col != '0);
    assign w_empty      = (attr_data == '0) || (w_attr.id == '0) || (w_attr.dim == '0);
    assign w_diff       = {1'b0, r_line_y} - {1'b0, w_attr.y};
    assign w_hit        = !w_empty && (r_line_y >= w_attr.y) && (w_diff < {4'b0, w_attr.dim});
    assign w_push       = w_eval && w_hit;
    assign w_new        = '{x: w_attr.x, row: w_diff[6:0], dim: w_attr.dim, id: w_attr.id};
    assign w_count_next = w_count + CNT_W'(w_push && !w_full);

    sprite_active_list #(
        .MAX_ACTIVE (MAX_ACTIVE)
    ) u_list (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (line_start),
        .i_push     (w_push),
        .i_entry    (w_new),
        .i_rd_idx   (r_fidx),
        .o_full     (w_full),
        .o_count    (w_count),
        .o_rd_entry (w_cur)
    );

    assign w_issue    = (r_state == FETCH) && !r_drain;
    assign w_rom_addr = 10'(15'(w_cur.row) * 15'(w_cur.dim) + 15'(r_col));
    assign w_col_abs  = {1'b0, w_cur.x} + 11'(r_col);

    assign attr_idx = ((r_state == SCAN) && (r_col < COL_W'(NUM_SLOTS))) ? 5'(r_col) : '0;
    assign rom_sel  = w_issue ? w_cur.id : '0;
    assign rom_addr = w_issue ? w_rom_addr : '0;
    // ROM data lands one cycle after its address, so the write side forwards it directly.
    assign lb_we    = (r_state == CLEAR) || (r_vld_p1 && r_inb_p1 && (rom_data != TRANSPARENT));
    assign lb_addr  = r_vld_p1 ? r_addr_p1 : ((r_state == CLEAR) ? 10'(r_col) : '0);
    assign lb_data  = r_vld_p1 ? rom_data  : ((r_state == CLEAR) ? BG_COLOR : '0);

    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;
    assign late     = r_late;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_col      <= '0;
            r_fidx     <= '0;
            r_drain    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_late     <= 1'b0;
            r_vld_p1   <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_late   <= 1'b0;
            r_vld_p1 <= w_issue && !line_start;
            if (line_start) begin
                r_late     <= (r_state != IDLE);
                r_state    <= CLEAR;
                r_col      <= '0;
                r_busy     <= 1'b1;
                r_overflow <= 1'b0;
            end else begin
                if (w_push && w_full) begin
                    r_overflow <= 1'b1;
                end
                case (r_state)
                    IDLE: begin
                        r_col <= '0;
                    end
                    CLEAR: begin
                        if (r_col == COL_W'(LINE_W - 1)) begin
                            r_state <= SCAN;
                            r_col   <= '0;
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                    SCAN: begin
                        if (r_col == COL_W'(NUM_SLOTS)) begin
                            r_col   <= '0;
                            r_drain <= 1'b0;
                            if (w_count_next == '0) begin
                                r_state <= DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= FETCH;
                                r_fidx  <= IDX_W'(w_count_next - CNT_W'(1));
                            end
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                    FETCH: begin
                        // Newest entry first so the lowest slot is written last and wins.
                        if (r_drain) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (r_col == COL_W'(w_cur.dim - 7'd1)) begin
                            r_col <= '0;
                            if (r_fidx == '0) begin
                                r_drain <= 1'b1;
                            end else begin
                                r_fidx <= r_fidx - IDX_W'(1);
                            end
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Pixel pipeline stage p1: column and clip flag travel with the ROM read.
    always_ff @(posedge clk) begin
        if (line_start) begin
            r_line_y <= line_y;
        end
        r_addr_p1 <= 10'(w_col_abs);
        r_inb_p1  <= (w_col_abs < 11'(LINE_W));
    end

endmodule

// File: doc/sprite_line_scheduler.md
# sprite_line_scheduler

Per-scanline sequencer for the sprite pipeline. On each line-start pulse it clears the prefetch line buffer to the background colour and scans the sprite attribute table for sprites that cover the next line. It then streams each hit sprite's row from the sprite ROMs into the line buffer, so the display side only ever reads a finished line. It sits between the attribute register file, the per-sprite ROM mux and the write port of the prefetch line buffer.

## Interface
Parameters:
- NUM_SLOTS, 20: attribute table entries scanned per line
- MAX_ACTIVE, 8: max sprites drawn per line
- MAX_DIM, 32: largest legal sprite dimension
- LINE_W, 640: visible pixels per line
- BG_COLOR, 24'h3DBCFB: background fill
- TRANSPARENT, 24'hFF00FF: ROM colour key; pixels with this value are not written

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high
- line_start  in  1  one-cycle pulse that starts preparation of line line_y
- line_y  in  10  line to render; sampled on line_start
- attr_idx  out  5  attribute table read index
- attr_data  in  32  {dim[31:25], id[24:20], y[19:10], x[9:0]}; valid 1 cycle after attr_idx
- rom_sel  out  5  sprite id selecting the ROM
- rom_addr  out  10  pixel address in the selected ROM
- rom_data  in  24  RGB; valid 1 cycle after rom_sel/rom_addr
- lb_we  out  1  line buffer write enable
- lb_addr  out  10  line buffer column
- lb_data  out  24  RGB to write
- busy  out  1  high from the cycle after line_start until done
- done  out  1  one-cycle pulse when the line is complete
- overflow  out  1  more than MAX_ACTIVE hits on the last line; held until the next line_start
- late  out  1  one-cycle pulse when line_start arrives while busy

## Operation
- FSM states: IDLE, CLEAR, SCAN, FETCH, DONE.
- IDLE: on line_start, latch line_y, clear the active list and overflow, go to CLEAR.
- CLEAR: write BG_COLOR to columns 0..LINE_W-1, one per cycle, then go to SCAN.
- SCAN: issue attr_idx 0..NUM_SLOTS-1 on consecutive cycles and evaluate each word one cycle later.
  - Empty slot: word==0, id==0 or dim==0.
  - Hit: line_y >= y and (line_y - y) < dim, computed at 11 bits so there is no wrap.
  - On a hit, push {x, row=line_y-y, dim, id}.
  - Push attempt while the list is full: drop the entry and set overflow.
- FETCH: visit list entries from the last pushed to the first, so lower slot numbers are drawn last and end up on top.
  - Per entry, col runs 0..dim-1, one per cycle: rom_sel=id, rom_addr=row*dim+col (truncated to 10 bits).
  - One cycle later: lb_addr=x+col, lb_data=rom_data, lb_we=1 only if x+col < LINE_W (11-bit sum) and rom_data != TRANSPARENT.
  - Entries stream back to back with no bubble.
  - Empty list: FETCH is skipped.
- DONE: pulse done, return to IDLE.
- line_start while not IDLE: abort the current line, pulse late, restart at CLEAR with the new line_y. Any partial line buffer content is overwritten by the restart.
- dim > MAX_DIM is illegal; no check is made and the row*dim product wraps at 10 bits.

## Timing
- Reset values: state IDLE; attr_idx, rom_sel, rom_addr, lb_addr, lb_data = 0; lb_we, busy, done, overflow, late = 0.
- First CLEAR write (column 0) is the cycle after line_start.
- CLEAR lasts LINE_W cycles; SCAN lasts NUM_SLOTS+1 cycles.
- FETCH lasts (sum of dims)+1 cycles; the last write is 1 cycle after the last ROM address.
- done is asserted the cycle after the last write.
- Worst case with defaults: 640+21+256+1+1 = 919 cycles, which fits a 1600-cycle line at 50 MHz.
- busy falls in the same cycle that done rises.

## Structure
- Package sprite_pkg:
  - sprite_attr_t packed struct {dim, id, y, x}
  - active_entry_t {x, row, dim, id}
  - state enum
  - BG_COLOR, TRANSPARENT, LINE_W
- Sub-module sprite_active_list: MAX_ACTIVE-entry register file with clear, push, full, count and indexed read. Top-level FSM and pixel pipeline: approx. 200 lines.

## Test plan
- Empty table, line_start with line_y=10: 640 BG writes, no FETCH writes, done at cycle 662.
- Slot 0 = {dim 16, id 1, y 5, x 100}, line_y=12:
  - rom_addr 112..127
  - writes to columns 100..115
  - done at cycle 679
- Slots 0 and 1 overlapping at x=100, both dim 8, ids 1 and 2: column 100 is written by slot 1 first, then by slot 0; slot 0 data is the final value.
- Sprite at x=630, dim 16: only columns 630..639 are written; TRANSPARENT ROM pixels produce no lb_we.
- Ten hits on one line: overflow=1, slots 0..7 drawn, slots 8 and 9 not drawn.
- line_start again during FETCH: late pulse, restart from column 0 CLEAR; reset asserted mid-SCAN: all outputs return to their reset values on the next cycle.
